// File: rtl/conv_line_buffer.sv
// ---------------------------------------------------------------------------
// conv_line_buffer
//
// K-row line buffer for the convolution layer. Accepts a raster-ordered pixel
// stream through a valid/ready handshake and presents KERNEL_ROWS complete
// image rows as one wide window bus. While the kernel stage works on the
// current window, the next image row is prefetched into a shadow row so that
// advancing the window normally costs no bubble.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   frame_start  one-cycle pulse that (re)starts a frame
//   in_valid     pixel valid
//   in_ready     pixel accepted when in_valid & in_ready
//   in_data      pixel value, raster order
//   win_valid    win_data holds KERNEL_ROWS valid rows
//   win_advance  consumer finished with the window (ignored while !win_valid)
//   win_data     window rows, row 0 (oldest) in the MSBs; within a row,
//                column 0 sits in the most significant pixel slot
//   win_row_idx  image row index of window row 0
//   frame_done   one-cycle pulse after the last window of a frame is consumed
// ---------------------------------------------------------------------------
module conv_line_buffer #(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int KERNEL_ROWS  = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          frame_start,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [DATA_WIDTH-1:0]                         in_data,
  output logic                                          win_valid,
  input  logic                                          win_advance,
  output logic [KERNEL_ROWS*IMAGE_WIDTH*DATA_WIDTH-1:0] win_data,
  output logic [$clog2(IMAGE_HEIGHT+1)-1:0]             win_row_idx,
  output logic                                          frame_done
);

  localparam int COL_W    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int ROW_W    = $clog2(IMAGE_HEIGHT + 1);
  localparam int ROW_BITS = IMAGE_WIDTH * DATA_WIDTH;
  localparam int WIN_BITS = KERNEL_ROWS * ROW_BITS;

  localparam logic [COL_W-1:0] LAST_COL    = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] HEIGHT_R    = ROW_W'(IMAGE_HEIGHT);
  localparam logic [ROW_W-1:0] FILL_LAST_R = ROW_W'(KERNEL_ROWS - 1);
  localparam logic [ROW_W-1:0] LAST_IDX_R  = ROW_W'(IMAGE_HEIGHT - KERNEL_ROWS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] WINDOW = 2'd2;
  localparam logic [1:0] STALL  = 2'd3;

  logic [1:0]            state_r;
  logic [COL_W-1:0]      col_r;
  logic [ROW_W-1:0]      rows_in_r;
  logic                  shadow_full_r;
  logic [DATA_WIDTH-1:0] shadow_r [IMAGE_WIDTH];
  logic [WIN_BITS-1:0]   rows_r;

  logic [1:0]            state_nx_s;
  logic [COL_W-1:0]      col_nx_s;
  logic [ROW_W-1:0]      rows_in_nx_s;
  logic [ROW_W-1:0]      idx_nx_s;
  logic                  shadow_full_nx_s;
  logic                  commit_s;
  logic                  frame_done_nx_s;
  logic                  in_ready_nx_s;
  logic                  accept_s;
  logic                  last_px_s;
  logic [ROW_BITS-1:0]   merged_s;
  logic [WIN_BITS-1:0]   rows_nx_s;

  // A frame_start pulse takes priority, so a pixel offered in that cycle is dropped.
  assign accept_s  = in_valid & in_ready & ~frame_start;
  assign last_px_s = accept_s & (col_r == LAST_COL);
  assign win_data  = rows_r;

  // Flatten the shadow row, merging in the pixel accepted this cycle so a
  // row can commit on the same edge its final pixel arrives.
  always_comb begin
    merged_s = {ROW_BITS{1'b0}};
    for (int c = 0; c < IMAGE_WIDTH; c++) begin
      if (accept_s && (col_r == COL_W'(c))) begin
        merged_s[(IMAGE_WIDTH-1-c)*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end else begin
        merged_s[(IMAGE_WIDTH-1-c)*DATA_WIDTH +: DATA_WIDTH] = shadow_r[c];
      end
    end
  end

  // Row commit: every row moves one slot toward row 0, the new row enters last.
  always_comb begin
    rows_nx_s                 = rows_r << ROW_BITS;
    rows_nx_s[ROW_BITS-1:0]   = merged_s;
  end

  // Next-state, counter and handshake logic of the fill/window/stall FSM.
  always_comb begin
    state_nx_s       = state_r;
    col_nx_s         = col_r;
    rows_in_nx_s     = rows_in_r;
    idx_nx_s         = win_row_idx;
    shadow_full_nx_s = shadow_full_r;
    commit_s         = 1'b0;
    frame_done_nx_s  = 1'b0;

    if (frame_start) begin
      // Abort or begin a frame; stored row data is simply overwritten later.
      state_nx_s       = FILL;
      col_nx_s         = {COL_W{1'b0}};
      rows_in_nx_s     = {ROW_W{1'b0}};
      idx_nx_s         = {ROW_W{1'b0}};
      shadow_full_nx_s = 1'b0;
    end else begin
      if (accept_s) begin
        col_nx_s = last_px_s ? {COL_W{1'b0}} : (col_r + COL_W'(1));
      end else begin
        col_nx_s = col_r;
      end

      case (state_r)
        FILL: begin
          if (last_px_s) begin
            commit_s     = 1'b1;
            rows_in_nx_s = rows_in_r + ROW_W'(1);
            if (rows_in_r == FILL_LAST_R) begin
              state_nx_s = WINDOW;
              idx_nx_s   = {ROW_W{1'b0}};
            end else begin
              state_nx_s = FILL;
            end
          end else begin
            state_nx_s = FILL;
          end
        end
        WINDOW: begin
          if (win_advance) begin
            if (win_row_idx == LAST_IDX_R) begin
              state_nx_s      = IDLE;
              frame_done_nx_s = 1'b1;
            end else if (shadow_full_r) begin
              // Prefetched row is complete: slide without a bubble.
              commit_s         = 1'b1;
              shadow_full_nx_s = 1'b0;
              rows_in_nx_s     = rows_in_r + ROW_W'(1);
              idx_nx_s         = win_row_idx + ROW_W'(1);
            end else if (last_px_s) begin
              commit_s     = 1'b1;
              rows_in_nx_s = rows_in_r + ROW_W'(1);
              idx_nx_s     = win_row_idx + ROW_W'(1);
            end else if (rows_in_r < HEIGHT_R) begin
              state_nx_s = STALL;
            end else begin
              state_nx_s = WINDOW;
            end
          end else begin
            // Hold a completed row until the consumer releases the window.
            if (last_px_s) begin
              shadow_full_nx_s = 1'b1;
            end else begin
              shadow_full_nx_s = shadow_full_r;
            end
          end
        end
        STALL: begin
          if (last_px_s) begin
            commit_s     = 1'b1;
            rows_in_nx_s = rows_in_r + ROW_W'(1);
            idx_nx_s     = win_row_idx + ROW_W'(1);
            state_nx_s   = WINDOW;
          end else begin
            state_nx_s = STALL;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // in_ready is registered, so it is derived from the state being entered.
  always_comb begin
    case (state_nx_s)
      FILL:    in_ready_nx_s = 1'b1;
      STALL:   in_ready_nx_s = 1'b1;
      WINDOW:  in_ready_nx_s = (rows_in_nx_s < HEIGHT_R) && !shadow_full_nx_s;
      default: in_ready_nx_s = 1'b0;
    endcase
  end

  // State, counters, row storage and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      col_r         <= {COL_W{1'b0}};
      rows_in_r     <= {ROW_W{1'b0}};
      shadow_full_r <= 1'b0;
      rows_r        <= {WIN_BITS{1'b0}};
      for (int c = 0; c < IMAGE_WIDTH; c++) begin
        shadow_r[c] <= {DATA_WIDTH{1'b0}};
      end
      in_ready      <= 1'b0;
      win_valid     <= 1'b0;
      win_row_idx   <= {ROW_W{1'b0}};
      frame_done    <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      col_r         <= col_nx_s;
      rows_in_r     <= rows_in_nx_s;
      shadow_full_r <= shadow_full_nx_s;
      if (accept_s) begin
        shadow_r[col_r] <= in_data;
      end
      if (commit_s) begin
        rows_r <= rows_nx_s;
      end
      in_ready      <= in_ready_nx_s;
      win_valid     <= (state_nx_s == WINDOW);
      win_row_idx   <= idx_nx_s;
      frame_done    <= frame_done_nx_s;
    end
  end

endmodule

// File: tb/tb_conv_line_buffer.sv
module tb_conv_line_buffer;

  localparam int WB = 2560;

  logic clk;
  logic rst;

  // Instance 0: 3 rows x 8 px x 8 rows
  logic        fs0, iv0, rdy0, wv0, adv0, fd0;
  logic [31:0] id0;
  logic [767:0] wd0;
  logic [3:0]  idx0;

  // Instance 1: 5 rows x 16 px x 8 rows
  logic        fs1, iv1, rdy1, wv1, adv1, fd1;
  logic [31:0] id1;
  logic [2559:0] wd1;
  logic [3:0]  idx1;

  int n_pass;
  int n_total;

  typedef struct {
    int feed_first;
    int feed_n;
    int mode;        // 0: feed then pulse advance, 1: advance with last pixel
    bit exp_valid;
    int exp_idx;
    int exp_first;
    bit exp_done;
    bit exp_ready;
  } vec_t;

  vec_t tbl [4];

  conv_line_buffer #(.DATA_WIDTH(32), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .KERNEL_ROWS(3)) u0 (
    .clk(clk), .rst(rst), .frame_start(fs0), .in_valid(iv0), .in_ready(rdy0),
    .in_data(id0), .win_valid(wv0), .win_advance(adv0), .win_data(wd0),
    .win_row_idx(idx0), .frame_done(fd0)
  );

  conv_line_buffer #(.DATA_WIDTH(32), .IMAGE_WIDTH(16), .IMAGE_HEIGHT(8), .KERNEL_ROWS(5)) u1 (
    .clk(clk), .rst(rst), .frame_start(fs1), .in_valid(iv1), .in_ready(rdy1),
    .in_data(id1), .win_valid(wv1), .win_advance(adv1), .win_data(wd1),
    .win_row_idx(idx1), .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected window: row r, column c holds first + r*iw + c.
  function automatic logic [WB-1:0] exp_win(input int k, input int iw, input int first);
    logic [WB-1:0] e;
    e = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < iw; c++)
        e[((k-1-r)*iw + (iw-1-c))*32 +: 32] = 32'(first + r*iw + c);
    return e;
  endfunction

  task automatic chk(input string name, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    int w;
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      w = 0;
      for (int i = 79; i >= 0; i--)
        if (got[i*32 +: 32] !== exp[i*32 +: 32]) w = i;
      $display("FAIL %s: word %0d actual %h required %h", name, w, got[w*32 +: 32], exp[w*32 +: 32]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one pixel and wait (bounded) until it is accepted.
  task automatic send_px(input int sel, input logic [31:0] val);
    logic rdy;
    bit   done;
    int   n;
    if (sel == 0) begin iv0 = 1'b1; id0 = val; end
    else          begin iv1 = 1'b1; id1 = val; end
    done = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      rdy = (sel == 0) ? rdy0 : rdy1;
      cyc();
      n++;
      done = rdy;
    end
    if (!done) begin
      n_total++;
      $display("FAIL accept_timeout: pixel %0d not accepted within 50 cycles", val);
    end
    if (sel == 0) iv0 = 1'b0;
    else          iv1 = 1'b0;
  endtask

  task automatic send_run(input int sel, input int first, input int n);
    for (int p = 0; p < n; p++) send_px(sel, 32'(first + p));
  endtask

  task automatic pulse_adv0();
    adv0 = 1'b1;
    cyc();
    adv0 = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1;
    fs0 = 1'b0; iv0 = 1'b0; id0 = '0; adv0 = 1'b0;
    fs1 = 1'b0; iv1 = 1'b0; id1 = '0; adv1 = 1'b0;

    tbl[0] = '{feed_first: 41, feed_n: 8, mode: 0, exp_valid: 1'b1, exp_idx: 3, exp_first: 25, exp_done: 1'b0, exp_ready: 1'b1};
    tbl[1] = '{feed_first: 49, feed_n: 8, mode: 1, exp_valid: 1'b1, exp_idx: 4, exp_first: 33, exp_done: 1'b0, exp_ready: 1'b1};
    tbl[2] = '{feed_first: 57, feed_n: 8, mode: 0, exp_valid: 1'b1, exp_idx: 5, exp_first: 41, exp_done: 1'b0, exp_ready: 1'b0};
    tbl[3] = '{feed_first: 0,  feed_n: 0, mode: 0, exp_valid: 1'b0, exp_idx: 5, exp_first: 0,  exp_done: 1'b1, exp_ready: 1'b0};

    // Reset state
    repeat (2) cyc();
    chk("rst_in_ready", WB'(rdy0), WB'(0));
    chk("rst_win_valid", WB'(wv0), WB'(0));
    chk("rst_idx", WB'(idx0), WB'(0));
    chk("rst_frame_done", WB'(fd0), WB'(0));
    chk("rst_win_data", WB'(wd0), WB'(0));
    rst = 1'b0;
    cyc();
    chk("idle_in_ready", WB'(rdy0), WB'(0));

    // T1: fill three rows
    fs0 = 1'b1; cyc(); fs0 = 1'b0;
    chk("fill_in_ready", WB'(rdy0), WB'(1));
    send_run(0, 1, 23);
    chk("t1_valid_before_last", WB'(wv0), WB'(0));
    send_px(0, 32'd24);
    chk("t1_win_valid", WB'(wv0), WB'(1));
    chk("t1_idx", WB'(idx0), WB'(0));
    chk("t1_data", WB'(wd0), exp_win(3, 8, 1));

    // T2: prefetch a full shadow row, then slide without a bubble
    send_run(0, 25, 8);
    chk("t2_ready_drop", WB'(rdy0), WB'(0));
    chk("t2_data_held", WB'(wd0), exp_win(3, 8, 1));
    pulse_adv0();
    chk("t2_win_valid", WB'(wv0), WB'(1));
    chk("t2_idx", WB'(idx0), WB'(1));
    chk("t2_data", WB'(wd0), exp_win(3, 8, 9));
    chk("t2_ready_back", WB'(rdy0), WB'(1));

    // T3: advance with empty shadow stalls until the next row lands
    pulse_adv0();
    chk("t3_stall_valid", WB'(wv0), WB'(0));
    chk("t3_stall_ready", WB'(rdy0), WB'(1));
    send_run(0, 33, 8);
    chk("t3_win_valid", WB'(wv0), WB'(1));
    chk("t3_idx", WB'(idx0), WB'(2));
    chk("t3_data", WB'(wd0), exp_win(3, 8, 17));

    // T4: rest of the frame, table driven
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < tbl[i].feed_n; p++) begin
        if (tbl[i].mode == 1 && p == tbl[i].feed_n - 1) adv0 = 1'b1;
        send_px(0, 32'(tbl[i].feed_first + p));
        adv0 = 1'b0;
      end
      if (tbl[i].mode == 0) pulse_adv0();
      chk($sformatf("t4_%0d_valid", i), WB'(wv0), WB'(tbl[i].exp_valid));
      chk($sformatf("t4_%0d_idx", i), WB'(idx0), WB'(tbl[i].exp_idx));
      chk($sformatf("t4_%0d_done", i), WB'(fd0), WB'(tbl[i].exp_done));
      chk($sformatf("t4_%0d_ready", i), WB'(rdy0), WB'(tbl[i].exp_ready));
      if (tbl[i].exp_valid)
        chk($sformatf("t4_%0d_data", i), WB'(wd0), exp_win(3, 8, tbl[i].exp_first));
    end
    cyc();
    chk("t4_done_pulse_end", WB'(fd0), WB'(0));
    chk("t4_idle_ready", WB'(rdy0), WB'(0));

    // T5: abort a partial frame; the pixel offered with frame_start is dropped
    fs0 = 1'b1; cyc(); fs0 = 1'b0;
    send_run(0, 101, 13);
    fs0 = 1'b1; iv0 = 1'b1; id0 = 32'd999;
    cyc();
    fs0 = 1'b0; iv0 = 1'b0;
    chk("t5_restart_ready", WB'(rdy0), WB'(1));
    chk("t5_restart_valid", WB'(wv0), WB'(0));
    send_run(0, 201, 23);
    chk("t5_valid_before_last", WB'(wv0), WB'(0));
    send_px(0, 32'd224);
    chk("t5_win_valid", WB'(wv0), WB'(1));
    chk("t5_idx", WB'(idx0), WB'(0));
    chk("t5_data", WB'(wd0), exp_win(3, 8, 201));

    // T6: asynchronous reset in the middle of a window
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", WB'(wv0), WB'(0));
    chk("t6_rst_ready", WB'(rdy0), WB'(0));
    chk("t6_rst_data", WB'(wd0), WB'(0));
    chk("t6_rst_idx", WB'(idx0), WB'(0));
    repeat (2) cyc();
    chk("t6_rst_no_done", WB'(fd0), WB'(0));
    rst = 1'b0;
    cyc();

    // T6b: 5x16 configuration
    fs1 = 1'b1; cyc(); fs1 = 1'b0;
    send_run(1, 1, 79);
    chk("t6b_valid_before_last", WB'(wv1), WB'(0));
    send_px(1, 32'd80);
    chk("t6b_win_valid", WB'(wv1), WB'(1));
    chk("t6b_idx", WB'(idx1), WB'(0));
    chk("t6b_data", wd1, exp_win(5, 16, 1));
    #2 rst = 1'b1;
    #1;
    chk("t6b_rst_valid", WB'(wv1), WB'(0));
    chk("t6b_rst_data", wd1, WB'(0));
    cyc();
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
